// File: rtl/mem_dual_port.sv
// Dual-port word memory: a CPU port with byte strobes and write priority, plus a calculator
// port whose colliding writes wait in a one-entry buffer. Define MEM_RDW_BYPASS_EN for read-during-write bypass.
module mem_dual_port #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_LSB = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_we,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic                cpu_re,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  input  logic [31:0]         calc_addr,
  input  logic [DATA_W-1:0]   calc_wdata,
  input  logic                calc_we,
  input  logic                calc_re,
  output logic [DATA_W-1:0]   calc_rdata,
  output logic                calc_rvalid,
  output logic                calc_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, PENDING} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     buf_idx_q, buf_idx_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] calc_rdata_q, calc_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              calc_rvalid_q, calc_rvalid_d;

  logic [AW-1:0]     cpu_idx, calc_idx, wr_idx;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data, wr_mask, cpu_word, calc_word;
  logic              calc_ok;
  logic              unused_addr_bits;

  assign cpu_idx          = cpu_addr[ADDR_LSB +: AW];
  assign calc_idx         = calc_addr[ADDR_LSB +: AW];
  assign unused_addr_bits = ^{cpu_addr, calc_addr};
  assign calc_ok          = (state_q == IDLE);

  // One write per cycle: CPU first, then a buffered calculator word, then a fresh calculator write.
  always_comb begin
    state_d    = state_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    wr_idx     = cpu_idx;
    wr_data    = cpu_wdata;
    wr_be      = '0;
    if (cpu_we) begin
      wr_be = cpu_be;
    end else if (state_q == PENDING) begin
      wr_idx  = buf_idx_q;
      wr_data = buf_data_q;
      wr_be   = '1;
      state_d = IDLE;
    end else if (calc_we) begin
      wr_idx  = calc_idx;
      wr_data = calc_wdata;
      wr_be   = '1;
    end
    if (calc_ok && calc_we && cpu_we) begin
      state_d    = PENDING;
      buf_idx_d  = calc_idx;
      buf_data_d = calc_wdata;
    end
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NB; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_be[b]}};
    end
  end

  always_comb begin
`ifdef MEM_RDW_BYPASS_EN
    cpu_word  = (wr_idx == cpu_idx) ? ((mem[cpu_idx] & ~wr_mask) | (wr_data & wr_mask))
                                    : mem[cpu_idx];
    calc_word = (wr_idx == calc_idx) ? ((mem[calc_idx] & ~wr_mask) | (wr_data & wr_mask))
                                     : mem[calc_idx];
`else
    cpu_word  = mem[cpu_idx];
    calc_word = mem[calc_idx];
`endif
  end

  always_comb begin
    cpu_rdata_d   = cpu_re ? cpu_word : cpu_rdata_q;
    cpu_rvalid_d  = cpu_re;
    calc_rdata_d  = (calc_re && calc_ok) ? calc_word : calc_rdata_q;
    calc_rvalid_d = calc_re && calc_ok;
  end

  // Array contents survive reset; only the control state and read outputs are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      buf_idx_q     <= '0;
      buf_data_q    <= '0;
      cpu_rdata_q   <= '0;
      calc_rdata_q  <= '0;
      cpu_rvalid_q  <= 1'b0;
      calc_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_idx_q     <= buf_idx_d;
      buf_data_q    <= buf_data_d;
      cpu_rdata_q   <= cpu_rdata_d;
      calc_rdata_q  <= calc_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      calc_rvalid_q <= calc_rvalid_d;
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign calc_rdata  = calc_rdata_q;
  assign calc_rvalid = calc_rvalid_q;
  assign calc_busy   = (state_q == PENDING);

endmodule

// File: tb/tb_mem_dual_port.sv
// Randomized self-checking bench for mem_dual_port against a word-array reference model.
// Honours MEM_RDW_BYPASS_EN when computing read-during-write expectations.
module tb_mem_dual_port;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, cpu_rvalid;
  logic [3:0]  cpu_be;
  logic [31:0] calc_addr, calc_wdata, calc_rdata;
  logic        calc_we, calc_re, calc_rvalid, calc_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [256];
  bit          mdl_busy;
  int unsigned mdl_buf_idx;
  logic [31:0] mdl_buf_data;
  logic [31:0] mdl_cpu_rd, mdl_calc_rd;
  bit          mdl_cpu_rv, mdl_calc_rv;

  mem_dual_port #(.DATA_W(32), .DEPTH(256), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .calc_addr(calc_addr), .calc_wdata(calc_wdata), .calc_we(calc_we), .calc_re(calc_re),
    .calc_rdata(calc_rdata), .calc_rvalid(calc_rvalid), .calc_busy(calc_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) % 256;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".cpu_rvalid"},  32'(cpu_rvalid),  32'(mdl_cpu_rv));
    checkOutput({tag, ".cpu_rdata"},   cpu_rdata,        mdl_cpu_rd);
    checkOutput({tag, ".calc_rvalid"}, 32'(calc_rvalid), 32'(mdl_calc_rv));
    checkOutput({tag, ".calc_rdata"},  calc_rdata,       mdl_calc_rd);
    checkOutput({tag, ".calc_busy"},   32'(calc_busy),   32'(mdl_busy));
  endtask

  // One clock cycle of stimulus; the model predicts the outcome from the memory's rules.
  task automatic applyStimulus(input string tag,
                               input bit cwe, input logic [3:0] cbe, input bit cre,
                               input logic [31:0] caddr, input logic [31:0] cdata,
                               input bit kwe, input bit kre,
                               input logic [31:0] kaddr, input logic [31:0] kdata);
    int unsigned ci, ki, w_idx;
    logic [31:0] w_val, cpu_val, calc_val;
    bit          wr, accept;
    cpu_we = cwe; cpu_be = cbe; cpu_re = cre; cpu_addr = caddr; cpu_wdata = cdata;
    calc_we = kwe; calc_re = kre; calc_addr = kaddr; calc_wdata = kdata;
    ci = word_of(caddr);
    ki = word_of(kaddr);
    accept = !mdl_busy;
    wr = 1'b1; w_idx = 0; w_val = '0;
    if (cwe) begin
      w_idx = ci; w_val = lane_merge(mdl_mem[ci], cdata, cbe);
    end else if (mdl_busy) begin
      w_idx = mdl_buf_idx; w_val = mdl_buf_data;
    end else if (kwe) begin
      w_idx = ki; w_val = kdata;
    end else begin
      wr = 1'b0;
    end
    cpu_val  = mdl_mem[ci];
    calc_val = mdl_mem[ki];
`ifdef MEM_RDW_BYPASS_EN
    if (wr && w_idx == ci) cpu_val = w_val;
    if (wr && w_idx == ki) calc_val = w_val;
`endif
    @(posedge clk);
    #1;
    if (wr) mdl_mem[w_idx] = w_val;
    mdl_cpu_rv = cre;
    if (cre) mdl_cpu_rd = cpu_val;
    mdl_calc_rv = kre && accept;
    if (kre && accept) mdl_calc_rd = calc_val;
    if (accept && kwe && cwe) begin
      mdl_busy = 1'b1; mdl_buf_idx = ki; mdl_buf_data = kdata;
    end else if (mdl_busy && !cwe) begin
      mdl_busy = 1'b0;
    end
    checkAll(tag);
  endtask

  task automatic idleInputs();
    cpu_we = 0; cpu_be = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    calc_we = 0; calc_re = 0; calc_addr = 0; calc_wdata = 0;
  endtask

  task automatic doReset(input string tag);
    idleInputs();
    rst = 1'b1;
    #1;
    mdl_busy = 0; mdl_cpu_rd = 0; mdl_calc_rd = 0; mdl_cpu_rv = 0; mdl_calc_rv = 0;
    checkAll(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    mdl_busy = 0; mdl_buf_idx = 0; mdl_buf_data = 0;
    mdl_cpu_rd = 0; mdl_calc_rd = 0; mdl_cpu_rv = 0; mdl_calc_rv = 0;
    doReset("reset0");

    for (int i = 0; i < 256; i++)
      applyStimulus("fill", 1, 4'hF, 0, 32'(i * 4), $urandom, 0, 0, 0, 0);

    applyStimulus("wr_10", 1, 4'hF, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    applyStimulus("rd_10", 0, 4'h0, 1, 32'h10, 0, 0, 0, 0, 0);
    checkOutput("dir_rd_10", cpu_rdata, 32'hDEADBEEF);
    checkOutput("dir_rvalid_hi", 32'(cpu_rvalid), 32'd1);
    applyStimulus("idle_10", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dir_rvalid_lo", 32'(cpu_rvalid), 32'd0);

    applyStimulus("lane_init", 1, 4'hF, 0, 32'h14, 32'h11223344, 0, 0, 0, 0);
    applyStimulus("lane_wr", 1, 4'h2, 0, 32'h14, 32'hAABBCCDD, 0, 0, 0, 0);
    applyStimulus("lane_be0", 1, 4'h0, 0, 32'h14, 32'hFFFFFFFF, 0, 0, 0, 0);
    applyStimulus("lane_rd", 0, 4'h0, 1, 32'h14, 0, 0, 1, 32'h14, 0);
    checkOutput("dir_lane", cpu_rdata, 32'h1122CC44);
    checkOutput("dir_same_word", calc_rdata, 32'h1122CC44);

    applyStimulus("coll", 1, 4'hF, 0, 32'h20, 32'h1, 1, 0, 32'h20, 32'h2);
    checkOutput("dir_busy_hi", 32'(calc_busy), 32'd1);
    applyStimulus("coll_hold", 1, 4'hF, 0, 32'h20, 32'h3, 1, 1, 32'h24, 32'h9);
    checkOutput("dir_busy_hold", 32'(calc_busy), 32'd1);
    applyStimulus("coll_commit", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dir_busy_lo", 32'(calc_busy), 32'd0);
    applyStimulus("coll_rd", 0, 4'h0, 1, 32'h20, 0, 0, 0, 0, 0);
    checkOutput("dir_coll_rd", cpu_rdata, 32'h2);

    applyStimulus("wrap_wr", 1, 4'hF, 0, 32'h400, 32'h55, 0, 0, 0, 0);
    applyStimulus("wrap_rd", 0, 4'h0, 1, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("dir_wrap", cpu_rdata, 32'h55);

    applyStimulus("rp_init", 1, 4'hF, 0, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0);
    applyStimulus("rp_coll", 1, 4'hF, 0, 32'h34, 32'h9, 1, 0, 32'h30, 32'h12345678);
    checkOutput("dir_rp_busy", 32'(calc_busy), 32'd1);
    doReset("rst_pend");
    applyStimulus("rp_idle", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rp_rd", 0, 4'h0, 1, 32'h30, 0, 0, 0, 0, 0);
    checkOutput("dir_rp_intact", cpu_rdata, 32'hCAFEF00D);

    applyStimulus("rdw_init", 1, 4'hF, 0, 32'h8, 32'h66, 0, 0, 0, 0);
    applyStimulus("rdw", 1, 4'hF, 1, 32'h8, 32'h77, 0, 1, 32'h8, 0);
`ifdef MEM_RDW_BYPASS_EN
    checkOutput("dir_rdw", cpu_rdata, 32'h77);
`else
    checkOutput("dir_rdw", cpu_rdata, 32'h66);
`endif
    applyStimulus("rdw_after", 0, 4'h0, 1, 32'h8, 0, 0, 0, 0, 0);
    checkOutput("dir_rdw_after", cpu_rdata, 32'h77);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ca, ka;
      ca = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      ka = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      if (n % 701 == 700) doReset("rand_rst");
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 4), 4'($urandom), ($urandom_range(0, 1) == 1), ca, $urandom,
                    ($urandom_range(0, 9) < 4), ($urandom_range(0, 1) == 1), ka, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_dual_port.md
MEM_DUAL_PORT -- requirements
Module: mem_dual_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_LSB, default 2, number of byte-offset bits dropped from each 32-bit address.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port cpu_addr, input, 32, CPU byte address (the ALU result).
REQ-007 SHALL have port cpu_wdata, input, DATA_W, CPU write data.
REQ-008 SHALL have port cpu_we, input, 1, CPU write enable.
REQ-009 SHALL have port cpu_be, input, DATA_W/8, CPU byte-lane write strobes.
REQ-010 SHALL have port cpu_re, input, 1, CPU read request.
REQ-011 SHALL have port cpu_rdata, output, DATA_W, CPU read data.
REQ-012 SHALL have port cpu_rvalid, output, 1, CPU read-data-valid pulse.
REQ-013 SHALL have port calc_addr, input, 32, calculator-port byte address.
REQ-014 SHALL have port calc_wdata, input, DATA_W, calculator write data; always full word.
REQ-015 SHALL have ports calc_we and calc_re, input, 1 each, calculator write enable and read request.
REQ-016 SHALL have ports calc_rdata (output, DATA_W), calc_rvalid (output, 1) and calc_busy (output, 1: pending write held, new requests refused).

Function
REQ-017 SHALL hold a DEPTH x DATA_W array with one write port and two read ports; contents are not reset.
REQ-018 SHALL form the word index as addr[ADDR_LSB +: log2(DEPTH)]; higher address bits are ignored, so addresses wrap modulo DEPTH.
REQ-019 SHALL make a read take 1 cycle: a read request at edge N loads rdata at edge N and drives rvalid high for exactly the following cycle.
REQ-020 SHALL hold the rdata outputs between reads.
REQ-021 SHALL give a CPU write priority and apply it at once, updating only the lanes with cpu_be set; cpu_be equal to 0 writes nothing.
REQ-022 SHALL use a 2-state FSM: IDLE and PENDING.
REQ-023 SHALL, in IDLE with calc_we high and cpu_we low, write calc_wdata in that cycle.
REQ-024 SHALL, in IDLE with calc_we and cpu_we both high on any addresses, latch the calculator address and data into a one-entry buffer and go to PENDING.
REQ-025 SHALL drive calc_busy high exactly while the FSM is in PENDING.
REQ-026 SHALL, in PENDING, commit the buffered word in the first cycle with cpu_we low, then return to IDLE; calc_busy falls on the next edge.
REQ-027 SHALL keep waiting while cpu_we stays high in PENDING; a same-word CPU write in that window is overwritten by the later buffered commit.
REQ-028 SHALL ignore calc_we and calc_re while calc_busy is high.
REQ-029 SHALL NOT be affected in CPU reads by calculator activity.
REQ-030 SHALL, for simultaneous reads of the same word on both ports, return identical data on both ports.

Reset
REQ-031 SHALL, on rst high, immediately clear cpu_rdata, calc_rdata, cpu_rvalid, calc_rvalid and calc_busy to 0 and set the FSM to IDLE.
REQ-032 SHALL discard any PENDING buffered write on reset, with array contents otherwise retained.
REQ-033 SHALL have rst deassertion take effect at the next rising edge, with no request accepted at that edge while rst was high before it.

Configuration
REQ-034 SHALL, with macro MEM_RDW_BYPASS_EN defined, make a read of the word being written in the same cycle return the newly written data (lane-merged for CPU writes), on either port.
REQ-035 SHALL, without MEM_RDW_BYPASS_EN, make a read of the word being written in the same cycle return the old data; the new data is visible from the next cycle.

Verification
REQ-036 SHALL test CPU write then read: cpu_we=1, addr 0x10, data 0xDEADBEEF, be=0xF; then cpu_re addr 0x10 -> next cycle cpu_rdata=0xDEADBEEF, cpu_rvalid=1 for one cycle.
REQ-037 SHALL test byte lanes: word holds 0x11223344; CPU write 0xAABBCCDD with be=0x2 -> readback 0x1122CC44.
REQ-038 SHALL test the collision: CPU writes 0x1 to addr 0x20 while calc writes 0x2 to addr 0x20 -> calc_busy=1 next cycle; with cpu_we low it falls; a read of 0x20 then returns 0x2.
REQ-039 SHALL test wrap: DEPTH=256, write 0x55 at addr 0x400 -> a read at addr 0x0 returns 0x55.
REQ-040 SHALL test reset mid-PENDING: pulse rst while calc_busy=1 -> outputs 0 immediately, buffered word never written, prior array data intact.
REQ-041 SHALL test read-during-write: write 0x77 to addr 0x8 with cpu_re on addr 0x8 in the same cycle -> 0x77 with MEM_RDW_BYPASS_EN, old value without it.
